// File: rtl/fp_decode_if.sv
// Handshake bundle for the floating-point decoder.
//   upstream  : in_valid/in_ready with payload S (sign), E (exponent), F (significand)
//   downstream: out_valid/out_ready with payload D (two's-complement linear value)
// master = producer/consumer side (testbench or neighbours), slave = decoder side.
interface fp_decode_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned EXP_W  = 3,
  parameter int unsigned MANT_W = 4
) ();
  logic              in_valid;
  logic              in_ready;
  logic              S;
  logic [EXP_W-1:0]  E;
  logic [MANT_W-1:0] F;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] D;

  modport master (
    output in_valid, S, E, F, out_ready,
    input  in_ready, out_valid, D
  );

  modport slave (
    input  in_valid, S, E, F, out_ready,
    output in_ready, out_valid, D
  );
endinterface

// File: rtl/fp_decode.sv
// Serial floating-point decoder: D = (-1)^S * F * 2^E as a DATA_W-bit
// two's-complement value. One left shift per cycle, then a sign-apply cycle.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : fp_decode_if.slave (in_valid/in_ready/S/E/F in, out_valid/out_ready/D out)
// in_ready is decoded from state (IDLE only); all other outputs are registered.
module fp_decode #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned EXP_W  = 3,
  parameter int unsigned MANT_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  fp_decode_if.slave   bus
);

  // Output must hold the largest shifted significand without overflow.
  if (DATA_W < MANT_W + (1 << EXP_W)) begin : g_width_check
    $error("fp_decode: DATA_W too small for MANT_W/EXP_W");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_SIGN,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mag_q, mag_d;
  logic [EXP_W-1:0]  cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic              out_valid_q, out_valid_d;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mag_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      d_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      d_q         <= d_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    d_d         = d_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          sign_d  = bus.S;
          cnt_d   = bus.E;
          mag_d   = DATA_W'(bus.F);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q - EXP_W'(1);
        end else begin
          state_d = ST_SIGN;
        end
      end
      ST_SIGN: begin
        // Full-width negation; a zero magnitude stays zero.
        d_d         = sign_q ? DATA_W'(~mag_q + DATA_W'(1)) : mag_q;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.D         = d_q;

endmodule

// File: tb/tb_fp_decode.sv
// Randomized self-checking bench for fp_decode against an arithmetic model.
module tb_fp_decode;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned EXP_W  = 3;
  localparam int unsigned MANT_W = 4;
  localparam int          MAX_WAIT = 40;

  logic clk;
  logic rst;

  fp_decode_if #(.DATA_W(DATA_W), .EXP_W(EXP_W), .MANT_W(MANT_W)) u_if ();

  fp_decode #(.DATA_W(DATA_W), .EXP_W(EXP_W), .MANT_W(MANT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: signed product F * 2^E, wrapped to DATA_W bits.
  function automatic logic [DATA_W-1:0] ref_d(input bit s, input int e, input int f);
    int m;
    m = f * (1 << e);
    return s ? DATA_W'(-m) : DATA_W'(m);
  endfunction

  task automatic scramble_inputs();
    u_if.in_valid = 1'($urandom);
    u_if.S        = 1'($urandom);
    u_if.E        = EXP_W'($urandom);
    u_if.F        = MANT_W'($urandom);
  endtask

  // Drive one word at the next negedge and let the following posedge accept it.
  task automatic accept_word(input bit s, input int e, input int f);
    @(negedge clk);
    check_eq("in_ready_idle", 32'(u_if.in_ready), 32'd1);
    u_if.in_valid = 1'b1;
    u_if.S        = s;
    u_if.E        = EXP_W'(e);
    u_if.F        = MANT_W'(f);
    @(posedge clk);
    #1;
    check_eq("in_ready_busy", 32'(u_if.in_ready), 32'd0);
    scramble_inputs();
  endtask

  // Full transaction: latency, result, hold under back-pressure, release.
  task automatic run_txn(input bit s, input int e, input int f, input int hold);
    logic [DATA_W-1:0] exp_d;
    int lat;
    bit seen;
    exp_d = ref_d(s, e, f);
    accept_word(s, e, f);
    lat  = 0;
    seen = 0;
    while (!seen && lat < MAX_WAIT) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (u_if.out_valid) begin
        seen = 1;
        u_if.out_ready = (hold == 0);
      end else begin
        check_eq("in_ready_shift", 32'(u_if.in_ready), 32'd0);
        scramble_inputs();
        u_if.out_ready = 1'($urandom);
      end
    end
    check_eq("out_valid_seen", 32'(seen), 32'd1);
    check_eq("latency", 32'(lat), 32'(e + 2));
    check_eq("d_value", 32'(u_if.D), 32'(exp_d));
    for (int i = 0; i < hold; i++) begin
      scramble_inputs();
      @(posedge clk);
      @(negedge clk);
      check_eq("hold_valid", 32'(u_if.out_valid), 32'd1);
      check_eq("hold_d", 32'(u_if.D), 32'(exp_d));
      check_eq("hold_in_ready", 32'(u_if.in_ready), 32'd0);
      if (i == hold - 1) u_if.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b0;
    check_eq("drop_valid", 32'(u_if.out_valid), 32'd0);
    check_eq("drop_in_ready", 32'(u_if.in_ready), 32'd1);
    check_eq("drop_d_kept", 32'(u_if.D), 32'(exp_d));
  endtask

  // Accept a word, advance 'cycles' edges, then reset asynchronously mid-cycle.
  task automatic reset_inflight(input bit s, input int e, input int f, input int cycles);
    accept_word(s, e, f);
    u_if.out_ready = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      scramble_inputs();
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_valid", 32'(u_if.out_valid), 32'd0);
    check_eq("rst_d", 32'(u_if.D), 32'd0);
    u_if.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_in_ready", 32'(u_if.in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_no_valid", 32'(u_if.out_valid), 32'd0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst            = 1'b1;
    u_if.in_valid  = 1'b0;
    u_if.S         = 1'b0;
    u_if.E         = '0;
    u_if.F         = '0;
    u_if.out_ready = 1'b0;
    #1;
    check_eq("por_valid", 32'(u_if.out_valid), 32'd0);
    check_eq("por_d", 32'(u_if.D), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("por_in_ready", 32'(u_if.in_ready), 32'd1);

    // Directed corner cases.
    run_txn(1'b0, 0, 4'b1000, 0);   // 0x008
    run_txn(1'b0, 7, 4'b1111, 0);   // 0x780
    run_txn(1'b1, 7, 4'b1111, 1);   // 0x880
    run_txn(1'b1, 3, 4'b0000, 0);   // 0x000, no negative zero
    run_txn(1'b1, 2, 4'b0101, 5);   // 0xFEC held under back-pressure

    // Reset in the third SHIFT cycle, then a clean word.
    reset_inflight(1'b0, 5, 4'b1001, 2);
    run_txn(1'b0, 1, 4'b0011, 0);   // 0x006

    // Reset while holding a result in DONE.
    reset_inflight(1'b1, 1, 4'b0111, 5);

    // Random words with random back-pressure.
    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)));
    end

    // Resets landing in random states.
    for (int n = 0; n < 6; n++) begin
      int e;
      e = int'($urandom_range(0, 7));
      reset_inflight(1'($urandom), e, int'($urandom_range(0, 15)),
                     int'($urandom_range(0, e + 3)));
      run_txn(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_decode.md
Name: fp_decode

Overview:
- Inverse of the FPCVT encode path: expands an 8-bit floating-point word (sign S, 3-bit exponent E, 4-bit significand F) back into a 12-bit two's-complement linear value, D = (-1)^S × F × 2^E.
- Sits downstream of the encoder/round stage; used for round-trip checking and for feeding linear consumers.
- Multi-cycle serial shifter with valid/ready handshakes on both sides. One left shift per cycle, then a sign-apply cycle.

Parameters:
- DATA_W, 12, width of the linear output D; must be >= MANT_W + 2^EXP_W.
- EXP_W, 3, exponent width.
- MANT_W, 4, significand width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  S/E/F present
- in_ready  output  1  block can accept (IDLE only)
- S  input  1  sign, 1 = negative
- E  input  EXP_W  exponent
- F  input  MANT_W  significand
- out_valid  output  1  D holds a completed result
- out_ready  input  1  consumer takes D
- D  output  DATA_W  two's-complement linear result

Behaviour:
- Reset (async, any state): state = IDLE, out_valid = 0, D = 0, internal mag/cnt/sign = 0, in_ready = 1 after release.
- All outputs are registered except in_ready, which is decoded from state (1 only in IDLE).
- States: IDLE, SHIFT, SIGN, DONE.
- IDLE, when in_valid = 1 (accept edge):
  - latch sign_r = S, cnt = E, mag = zero-extended F;
  - go to SHIFT.
- SHIFT:
  - if cnt != 0: mag <= mag << 1, cnt <= cnt - 1, stay in SHIFT;
  - if cnt == 0: go to SIGN.
- SIGN:
  - D <= sign_r ? (~mag + 1) : mag, truncated to DATA_W;
  - out_valid <= 1, go to DONE.
- DONE:
  - hold D and out_valid until out_ready = 1;
  - on that edge out_valid <= 0 and go to IDLE. D keeps its last value.
- Latency: out_valid rises E + 2 cycles after the accept edge. Throughput is one word per E + 4 cycles minimum, since DONE never accepts new input.
- in_valid in any state other than IDLE is ignored; S/E/F are not sampled.
- S/E/F changing after the accept edge has no effect on the result.
- Arithmetic:
  - magnitude range 0..1920 at the defaults, no overflow possible; no saturation logic.
  - negation is full two's complement over DATA_W.
  - F = 0 with S = 1 yields D = 0; there is no negative zero.
- Non-normalized F (F[MANT_W-1] = 0) is decoded literally; no normalization check.
- out_ready high while not in DONE has no effect.
- Reset asserted mid-SHIFT, SIGN or DONE: the in-flight result is discarded; out_valid = 0 and D = 0 immediately.

Test Plan:
- Assert rst during a random state -> out_valid = 0, D = 0x000 asynchronously; in_ready = 1 after release.
- S=0, E=0, F=1000b, out_ready=1 -> D = 0x008; out_valid rises 2 cycles after accept; in_ready = 0 while busy.
- S=0, E=7, F=1111b -> D = 0x780 (1920); out_valid rises 9 cycles after accept.
- S=1, E=7, F=1111b -> D = 0x880 (-1920). Then S=1, E=3, F=0000b -> D = 0x000.
- S=1, E=2, F=0101b with out_ready held low 5 cycles, in_valid pulsed throughout -> D = 0xFEC (-20) held stable; no new accept; out_ready=1 -> out_valid drops next cycle and IDLE resumes.
- Accept S=0, E=5, F=1001b; assert rst in cycle 3 of SHIFT -> out_valid never rises. New input S=0, E=1, F=0011b -> D = 0x006.
